cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Synthesizable run controller wrapping the single-cycle RISC-V core for on-board and simulated program runs. On a start pulse it holds the core in reset for a fixed number of cycles, releases it, and counts cycles until the core signals halt or a cycle budget expires. It then freezes the core and latches a halt code plus NUM_CH probe channels for LED/display readout. It is the parametrised, self-checking replacement for fixed-length cycle runs, and it sits between `top_level` I/O and the CPU core.

## Interface
- NUM_CH, 4, number of probe channels captured
- DATA_W, 32, probe and halt-code width
- CYC_W, 32, cycle counter width
- RESET_CYCLES, 2, cycles cpu_rst_out is held after start; must be ≥1
- MAX_CYCLES, 1004, cycle budget before timeout; must be ≥1 and < 2^CYC_W
- clk_in  input  1  single system clock
- rst_n_in  input  1  reset, asynchronous assert, active-low
- start_in  input  1  run request, level or pulse; rising edge detected internally
- halt_in  input  1  core halt strobe, for example ecall or a tohost store
- halt_code_in  input  DATA_W  exit code valid with halt_in
- probe_in  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- sel_in  input  max(1,$clog2(NUM_CH))  readout channel select
- cpu_rst_out  output  1  active-high reset to the core
- cpu_en_out  output  1  core clock enable
- busy_out, done_out, timeout_out, pass_out  output  1 each  status flags
- cycles_out  output  CYC_W  enabled-cycle count of the current or last run
- halt_code_out  output  DATA_W  latched exit code
- result_out  output  DATA_W  latched probe[sel_in]

## Operation
- State machine RC_IDLE → RC_RESET → RC_RUN → RC_DONE.
- RC_DONE → RC_RESET on a start edge, which reruns the program.
- RC_IDLE
  - cpu_rst_out=1, cpu_en_out=0.
  - A start edge enters RC_RESET.
- RC_RESET
  - cpu_rst_out=1.
  - cycles, captures and flags are cleared on entry.
  - Stays for exactly RESET_CYCLES cycles, then enters RC_RUN.
- RC_RUN
  - cpu_rst_out=0, cpu_en_out=1, busy_out=1.
  - cycles_out increments on every cycle with cpu_en_out=1 and saturates at all-ones.
- Halt
  - halt_in is sampled only when cpu_en_out=1.
  - On that edge, halt_code_in and all probe_in channels are captured and the FSM enters RC_DONE.
- Timeout
  - Triggered when the counter's next value would equal MAX_CYCLES with no halt.
  - Probes are captured, halt_code is kept at 0, timeout is set, and the FSM enters RC_DONE.
- Simultaneous halt and timeout: halt wins and timeout_out stays 0.
- RC_DONE
  - cpu_rst_out=0, cpu_en_out=0, so the core is frozen and its architectural state is readable.
  - done_out=1.
- pass_out = done_out & ~timeout_out & (halt_code_out == 0).
- Start edges in RC_RESET or RC_RUN are ignored.
- result_out is combinational from the capture bank through sel_in.
- sel_in ≥ NUM_CH yields 0.

## Timing
- Reset values:
  - state is RC_IDLE and cpu_rst_out=1.
  - Every other output is 0, including the edge-detector history.
- Asserting rst_n_in mid-run aborts immediately.
  - The core is held in reset and all captures are lost.
- Start edge sampled on edge N gives cpu_rst_out=1 from N+1 through N+RESET_CYCLES, and cpu_en_out=1 from N+RESET_CYCLES+1.
- Halt sampled on edge H:
  - done_out, halt_code_out and result_out are valid after H.
  - cpu_en_out=0 after H.
  - cycles_out includes the halting cycle.
- Timeout: done_out and timeout_out rise on the edge where the count reaches MAX_CYCLES, so cycles_out=MAX_CYCLES.

## Configuration
- RUN_CTRL_STEP_EN defined:
  - Adds two ports, step_mode_in (input, 1) and step_in (input, 1).
  - In RC_RUN with step_mode_in=1, cpu_en_out pulses high for one cycle per rising edge of step_in.
  - Halt, timeout and counting act only on enabled cycles.
  - step_mode_in may change at any time; the change takes effect on the next cycle.
- RUN_CTRL_STEP_EN undefined:
  - Neither port exists.
  - cpu_en_out is continuously 1 in RC_RUN.

## Structure
- Package run_ctrl_pkg holds:
  - the state enum rc_state_t (RC_IDLE, RC_RESET, RC_RUN, RC_DONE);
  - the default parameter constants;
  - a helper function for the sel width.
- Sub-module run_ctrl_capture holds:
  - the NUM_CH×DATA_W capture registers and halt-code register, with capture, clear and async-reset inputs;
  - the readout mux.
- The top module holds the FSM, counters and edge detectors.

## Test plan
- Start, then halt_in with code 0 after 37 enabled cycles, probe1=0xDEADBEEF, sel=1 → cpu_rst_out high for 2 cycles; done=1, pass=1, cycles_out=37, result_out=0xDEADBEEF, cpu_en_out=0.
- No halt with MAX_CYCLES=1004 → timeout_out=1, pass=0, cycles_out=1004, done exactly 1004 enabled cycles after release.
- halt_in asserted on the 1004th cycle → timeout_out=0, done=1, halt code latched.
- halt_code_in=3 → pass_out=0, halt_code_out=3.
- rst_n_in low at cycle 500 of a run → all outputs return to reset values at once, cpu_rst_out=1.
- A second start pulse during RC_RUN is ignored; a start in RC_DONE reruns and cycles_out restarts from 0.
- With RUN_CTRL_STEP_EN, step_mode_in=1 and 5 step pulses → exactly 5 cpu_en_out pulses and cycles_out=5.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types, default parameters and helpers for the CPU run controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    RC_IDLE  = 2'd0,
    RC_RESET = 2'd1,
    RC_RUN   = 2'd2,
    RC_DONE  = 2'd3
  } rc_state_t;

  localparam int RC_NUM_CH       = 4;
  localparam int RC_DATA_W       = 32;
  localparam int RC_CYC_W        = 32;
  localparam int RC_RESET_CYCLES = 2;
  localparam int RC_MAX_CYCLES   = 1004;

  function automatic int sel_w(input int n);
    if (n > 1) return $clog2(n);
    else return 1;
  endfunction

endpackage

// File: rtl/run_ctrl_capture.sv
// Capture bank for probe channels and halt code, with the channel readout mux.
module run_ctrl_capture
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CH = RC_NUM_CH,
  parameter int DATA_W = RC_DATA_W,
  localparam int SEL_W = sel_w(NUM_CH)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     cap_in,
  input  logic                     clr_in,
  input  logic [DATA_W-1:0]        code_in,
  input  logic [NUM_CH*DATA_W-1:0] probe_in,
  input  logic [SEL_W-1:0]         sel_in,
  output logic [DATA_W-1:0]        halt_code_out,
  output logic [DATA_W-1:0]        result_out
);

  logic [DATA_W-1:0] bank_r [NUM_CH];
  logic [DATA_W-1:0] code_r;

  // Capture registers: cleared at run start, loaded when the run ends.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      code_r <= {DATA_W{1'b0}};
      for (int k = 0; k < NUM_CH; k++) bank_r[k] <= {DATA_W{1'b0}};
    end else if (clr_in) begin
      code_r <= {DATA_W{1'b0}};
      for (int k = 0; k < NUM_CH; k++) bank_r[k] <= {DATA_W{1'b0}};
    end else if (cap_in) begin
      code_r <= code_in;
      for (int k = 0; k < NUM_CH; k++) bank_r[k] <= probe_in[k*DATA_W +: DATA_W];
    end
  end

  // Readout mux; selects beyond the last channel read as zero.
  always_comb begin
    result_out = {DATA_W{1'b0}};
    if ({1'b0, sel_in} < (SEL_W+1)'(NUM_CH)) result_out = bank_r[sel_in];
    else result_out = {DATA_W{1'b0}};
  end

  assign halt_code_out = code_r;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: resets, runs, and freezes the core, then latches results.
// Optional single-step support is compiled in with RUN_CTRL_STEP_EN.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CH       = RC_NUM_CH,
  parameter int DATA_W       = RC_DATA_W,
  parameter int CYC_W        = RC_CYC_W,
  parameter int RESET_CYCLES = RC_RESET_CYCLES,
  parameter int MAX_CYCLES   = RC_MAX_CYCLES,
  localparam int SEL_W       = sel_w(NUM_CH)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     start_in,
  input  logic                     halt_in,
  input  logic [DATA_W-1:0]        halt_code_in,
  input  logic [NUM_CH*DATA_W-1:0] probe_in,
  input  logic [SEL_W-1:0]         sel_in,
`ifdef RUN_CTRL_STEP_EN
  input  logic                     step_mode_in,
  input  logic                     step_in,
`endif
  output logic                     cpu_rst_out,
  output logic                     cpu_en_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     timeout_out,
  output logic                     pass_out,
  output logic [CYC_W-1:0]         cycles_out,
  output logic [DATA_W-1:0]        halt_code_out,
  output logic [DATA_W-1:0]        result_out
);

  rc_state_t         state_r;
  logic [CYC_W-1:0]  rst_cnt_r;
  logic [CYC_W-1:0]  cycles_r;
  logic              start_prev_r;
  logic              cpu_rst_r, cpu_en_r, busy_r, done_r, timeout_r, pass_r;
  logic              start_edge_s, run_en_s, halt_hit_s, limit_hit_s, cap_s, clr_s;
  logic [CYC_W-1:0]  cnt_next_s;
  logic [DATA_W-1:0] cap_code_s;

  // Start-request rising-edge history.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) start_prev_r <= 1'b0;
    else start_prev_r <= start_in;
  end

  assign start_edge_s = start_in & ~start_prev_r;

`ifdef RUN_CTRL_STEP_EN
  logic step_prev_r;

  // Step-request rising-edge history.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) step_prev_r <= 1'b0;
    else step_prev_r <= step_in;
  end

  assign run_en_s = step_mode_in ? (step_in & ~step_prev_r) : 1'b1;
`else
  assign run_en_s = 1'b1;
`endif

  // Saturating count, end-of-run detection, and what the capture bank loads.
  always_comb begin
    cnt_next_s  = cycles_r;
    halt_hit_s  = 1'b0;
    limit_hit_s = 1'b0;
    cap_code_s  = {DATA_W{1'b0}};
    if (&cycles_r) cnt_next_s = cycles_r;
    else cnt_next_s = cycles_r + {{(CYC_W-1){1'b0}}, 1'b1};
    if (state_r == RC_RUN && cpu_en_r) begin
      halt_hit_s  = halt_in;
      limit_hit_s = ~halt_in & (cnt_next_s == CYC_W'(MAX_CYCLES));
    end else begin
      halt_hit_s  = 1'b0;
      limit_hit_s = 1'b0;
    end
    if (halt_hit_s) cap_code_s = halt_code_in;
    else cap_code_s = {DATA_W{1'b0}};
  end

  assign cap_s = halt_hit_s | limit_hit_s;
  assign clr_s = start_edge_s & ((state_r == RC_IDLE) | (state_r == RC_DONE));

  // Run sequencing FSM with registered core controls and status flags.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r   <= RC_IDLE;
      rst_cnt_r <= {CYC_W{1'b0}};
      cycles_r  <= {CYC_W{1'b0}};
      cpu_rst_r <= 1'b1;
      cpu_en_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      pass_r    <= 1'b0;
    end else begin
      case (state_r)
        RC_IDLE, RC_DONE: begin
          if (start_edge_s) begin
            state_r   <= RC_RESET;
            rst_cnt_r <= {CYC_W{1'b0}};
            cycles_r  <= {CYC_W{1'b0}};
            cpu_rst_r <= 1'b1;
            cpu_en_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            pass_r    <= 1'b0;
          end
        end
        RC_RESET: begin
          if (rst_cnt_r == CYC_W'(RESET_CYCLES - 1)) begin
            state_r   <= RC_RUN;
            cpu_rst_r <= 1'b0;
            cpu_en_r  <= run_en_s;
            busy_r    <= 1'b1;
          end else begin
            rst_cnt_r <= rst_cnt_r + {{(CYC_W-1){1'b0}}, 1'b1};
          end
        end
        RC_RUN: begin
          if (cpu_en_r) cycles_r <= cnt_next_s;
          // Halt has priority over the budget limit on the same cycle.
          if (halt_hit_s) begin
            state_r  <= RC_DONE;
            cpu_en_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            pass_r   <= (halt_code_in == {DATA_W{1'b0}});
          end else if (limit_hit_s) begin
            state_r   <= RC_DONE;
            cpu_en_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            timeout_r <= 1'b1;
          end else begin
            cpu_en_r <= run_en_s;
          end
        end
        default: begin
          state_r   <= RC_IDLE;
          cpu_rst_r <= 1'b1;
          cpu_en_r  <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  run_ctrl_capture #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W)
  ) u_capture (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .cap_in       (cap_s),
    .clr_in       (clr_s),
    .code_in      (cap_code_s),
    .probe_in     (probe_in),
    .sel_in       (sel_in),
    .halt_code_out(halt_code_out),
    .result_out   (result_out)
  );

  assign cpu_rst_out = cpu_rst_r;
  assign cpu_en_out  = cpu_en_r;
  assign busy_out    = busy_r;
  assign done_out    = done_r;
  assign timeout_out = timeout_r;
  assign pass_out    = pass_r;
  assign cycles_out  = cycles_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl (default parameters).
// Step-mode scenario is included when RUN_CTRL_STEP_EN is defined.
module tb_cpu_run_ctrl;

  logic         clk_in = 1'b0;
  logic         rst_n_in, start_in, halt_in;
  logic [31:0]  halt_code_in;
  logic [127:0] probe_in;
  logic [1:0]   sel_in;
`ifdef RUN_CTRL_STEP_EN
  logic         step_mode_in, step_in;
`endif
  logic         cpu_rst_out, cpu_en_out, busy_out, done_out, timeout_out, pass_out;
  logic [31:0]  cycles_out, halt_code_out, result_out;
  logic [5:0]   flags;
  int total = 0;
  int bad = 0;

  always #5 clk_in = ~clk_in;

  cpu_run_ctrl dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .halt_in(halt_in),
    .halt_code_in(halt_code_in), .probe_in(probe_in), .sel_in(sel_in),
`ifdef RUN_CTRL_STEP_EN
    .step_mode_in(step_mode_in), .step_in(step_in),
`endif
    .cpu_rst_out(cpu_rst_out), .cpu_en_out(cpu_en_out), .busy_out(busy_out),
    .done_out(done_out), .timeout_out(timeout_out), .pass_out(pass_out),
    .cycles_out(cycles_out), .halt_code_out(halt_code_out), .result_out(result_out)
  );

  assign flags = {cpu_rst_out, cpu_en_out, busy_out, done_out, timeout_out, pass_out};

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  // Start pulse then wait until the core has been released (cycles_out == 0, enabled).
  task automatic start_and_release;
    start_in = 1'b1; tick; start_in = 1'b0; tick; tick;
  endtask

  task automatic test_reset;
    rst_n_in = 1'b0; tick; tick;
    total++; if (flags !== 6'b100000) begin bad++; $display("FAIL reset_flags: got %b want 100000", flags); end
    total++; if (cycles_out !== 32'd0) begin bad++; $display("FAIL reset_cycles: got %0d want 0", cycles_out); end
    total++; if (halt_code_out !== 32'd0 || result_out !== 32'd0) begin bad++; $display("FAIL reset_capture: got %h/%h want 0/0", halt_code_out, result_out); end
    rst_n_in = 1'b1; tick;
    total++; if (flags !== 6'b100000) begin bad++; $display("FAIL idle_flags: got %b want 100000", flags); end
  endtask

  task automatic test_halt;
    probe_in = {32'h01234567, 32'hCAFEF00D, 32'hDEADBEEF, 32'h11111111};
    sel_in = 2'd1;
    start_in = 1'b1; tick; start_in = 1'b0;
    total++; if (flags !== 6'b100000) begin bad++; $display("FAIL halt_rst1: got %b want 100000", flags); end
    tick;
    total++; if (flags !== 6'b100000) begin bad++; $display("FAIL halt_rst2: got %b want 100000", flags); end
    tick;
    total++; if (flags !== 6'b011000) begin bad++; $display("FAIL halt_release: got %b want 011000", flags); end
    total++; if (cycles_out !== 32'd0) begin bad++; $display("FAIL halt_cnt0: got %0d want 0", cycles_out); end
    repeat (36) tick;
    total++; if (cycles_out !== 32'd36 || done_out !== 1'b0) begin bad++; $display("FAIL halt_cnt36: got %0d/%b want 36/0", cycles_out, done_out); end
    halt_in = 1'b1; halt_code_in = 32'd0; tick; halt_in = 1'b0;
    total++; if (flags !== 6'b000101) begin bad++; $display("FAIL halt_flags: got %b want 000101", flags); end
    total++; if (cycles_out !== 32'd37) begin bad++; $display("FAIL halt_cycles: got %0d want 37", cycles_out); end
    total++; if (result_out !== 32'hDEADBEEF) begin bad++; $display("FAIL halt_result1: got %h want deadbeef", result_out); end
    sel_in = 2'd0; #1;
    total++; if (result_out !== 32'h11111111) begin bad++; $display("FAIL halt_result0: got %h want 11111111", result_out); end
    sel_in = 2'd3; #1;
    total++; if (result_out !== 32'h01234567) begin bad++; $display("FAIL halt_result3: got %h want 01234567", result_out); end
    probe_in = {4{32'h55555555}}; sel_in = 2'd1; tick; tick;
    total++; if (result_out !== 32'hDEADBEEF) begin bad++; $display("FAIL halt_hold: got %h want deadbeef", result_out); end
    total++; if (cycles_out !== 32'd37 || cpu_en_out !== 1'b0) begin bad++; $display("FAIL halt_frozen: got %0d/%b want 37/0", cycles_out, cpu_en_out); end
  endtask

  task automatic test_timeout;
    start_and_release;
    probe_in = {32'h0, 32'hA5A5A5A5, 32'h0, 32'h0}; sel_in = 2'd2;
    repeat (1003) tick;
    total++; if (cycles_out !== 32'd1003 || flags !== 6'b011000) begin bad++; $display("FAIL to_pre: got %0d/%b want 1003/011000", cycles_out, flags); end
    tick;
    total++; if (flags !== 6'b000110) begin bad++; $display("FAIL to_flags: got %b want 000110", flags); end
    total++; if (cycles_out !== 32'd1004) begin bad++; $display("FAIL to_cycles: got %0d want 1004", cycles_out); end
    total++; if (halt_code_out !== 32'd0 || result_out !== 32'hA5A5A5A5) begin bad++; $display("FAIL to_capture: got %h/%h want 0/a5a5a5a5", halt_code_out, result_out); end
  endtask

  task automatic test_halt_at_limit;
    start_and_release;
    repeat (1003) tick;
    halt_in = 1'b1; halt_code_in = 32'd5; tick; halt_in = 1'b0;
    total++; if (flags !== 6'b000100) begin bad++; $display("FAIL lim_flags: got %b want 000100", flags); end
    total++; if (cycles_out !== 32'd1004 || halt_code_out !== 32'd5) begin bad++; $display("FAIL lim_code: got %0d/%h want 1004/5", cycles_out, halt_code_out); end
  endtask

  task automatic test_bad_code;
    start_and_release;
    repeat (9) tick;
    halt_in = 1'b1; halt_code_in = 32'd3; tick; halt_in = 1'b0;
    total++; if (flags !== 6'b000100) begin bad++; $display("FAIL code3_flags: got %b want 000100", flags); end
    total++; if (halt_code_out !== 32'd3 || cycles_out !== 32'd10) begin bad++; $display("FAIL code3_value: got %h/%0d want 3/10", halt_code_out, cycles_out); end
  endtask

  task automatic test_abort;
    start_and_release;
    repeat (499) tick;
    total++; if (cycles_out !== 32'd499) begin bad++; $display("FAIL abort_pre: got %0d want 499", cycles_out); end
    rst_n_in = 1'b0; #1;
    total++; if (flags !== 6'b100000 || cycles_out !== 32'd0) begin bad++; $display("FAIL abort_now: got %b/%0d want 100000/0", flags, cycles_out); end
    total++; if (halt_code_out !== 32'd0 || result_out !== 32'd0) begin bad++; $display("FAIL abort_capture: got %h/%h want 0/0", halt_code_out, result_out); end
    #1 rst_n_in = 1'b1; tick;
    total++; if (flags !== 6'b100000) begin bad++; $display("FAIL abort_idle: got %b want 100000", flags); end
  endtask

  task automatic test_back_to_back;
    halt_code_in = 32'd0;
    start_and_release;
    repeat (10) tick;
    start_in = 1'b1; tick; start_in = 1'b0; tick;
    total++; if (flags !== 6'b011000 || cycles_out !== 32'd12) begin bad++; $display("FAIL b2b_ignore: got %b/%0d want 011000/12", flags, cycles_out); end
    halt_in = 1'b1; tick; halt_in = 1'b0;
    total++; if (flags !== 6'b000101 || cycles_out !== 32'd13) begin bad++; $display("FAIL b2b_done: got %b/%0d want 000101/13", flags, cycles_out); end
    start_in = 1'b1; tick; start_in = 1'b0;
    total++; if (flags !== 6'b100000 || cycles_out !== 32'd0) begin bad++; $display("FAIL b2b_rerun: got %b/%0d want 100000/0", flags, cycles_out); end
    tick;
    total++; if (flags !== 6'b100000) begin bad++; $display("FAIL b2b_rst2: got %b want 100000", flags); end
    tick;
    total++; if (flags !== 6'b011000) begin bad++; $display("FAIL b2b_release: got %b want 011000", flags); end
    repeat (4) tick;
    halt_in = 1'b1; tick; halt_in = 1'b0;
    total++; if (flags !== 6'b000101 || cycles_out !== 32'd5) begin bad++; $display("FAIL b2b_second: got %b/%0d want 000101/5", flags, cycles_out); end
  endtask

`ifdef RUN_CTRL_STEP_EN
  task automatic test_step;
    int pulses;
    pulses = 0;
    step_mode_in = 1'b1;
    start_and_release;
    total++; if (flags !== 6'b001000) begin bad++; $display("FAIL step_idle: got %b want 001000", flags); end
    for (int i = 0; i < 5; i++) begin
      step_in = 1'b1; tick; if (cpu_en_out) pulses++;
      step_in = 1'b0; tick; if (cpu_en_out) pulses++;
      tick; if (cpu_en_out) pulses++;
    end
    total++; if (pulses !== 5) begin bad++; $display("FAIL step_pulses: got %0d want 5", pulses); end
    total++; if (cycles_out !== 32'd5) begin bad++; $display("FAIL step_cycles: got %0d want 5", cycles_out); end
    step_mode_in = 1'b0; tick;
    total++; if (cpu_en_out !== 1'b1) begin bad++; $display("FAIL step_exit: got %b want 1", cpu_en_out); end
    halt_in = 1'b1; tick; halt_in = 1'b0;
    total++; if (done_out !== 1'b1 || cycles_out !== 32'd6) begin bad++; $display("FAIL step_halt: got %b/%0d want 1/6", done_out, cycles_out); end
  endtask
`endif

  initial begin
    rst_n_in = 1'b0; start_in = 1'b0; halt_in = 1'b0;
    halt_code_in = 32'd0; probe_in = 128'd0; sel_in = 2'd0;
`ifdef RUN_CTRL_STEP_EN
    step_mode_in = 1'b0; step_in = 1'b0;
`endif
    test_reset;
    test_halt;
    test_timeout;
    test_halt_at_limit;
    test_bad_code;
    test_abort;
    test_back_to_back;
`ifdef RUN_CTRL_STEP_EN
    test_step;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
